pcieifc_fifo_ptr_ctrl_ext: RTL and testbench

One-side pointer controller for the PCIe-interface dual-clock FIFO. One instance runs in the write domain and one in the read domain. It holds the local gray and binary pointers, synchronises the other side's gray pointer internally, and decodes that pointer. It generates the full/empty flags, the occupancy level, a registered programmable-threshold flag and a sticky overflow/underflow error. It supports any depth 2..2^ADDR_WIDTH, not just powers of two, and sits between the SRAM macro and the client logic on each side.

---
 rtl/pcieifc_fifo_ptr_ctrl_ext.sv | 121 ++++++++++++
 tb/tb_pcieifc_fifo_ptr_ctrl_ext.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcieifc_fifo_ptr_ctrl_ext.sv
// One-side pointer control for the dual-clock FIFO: local gray/binary pointer, remote-pointer sync/decode, flags.
// Flags are comb from registers; prog is registered (1 cycle); remote visible after SYNC_STAGES edges; blocked requests drop and set sticky err.
module pcieifc_fifo_ptr_ctrl_ext #(
   parameter int ADDR_WIDTH  = 5,
   parameter int FIFO_DEPTH  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IS_WRITE    = 1
) (
   input  logic                  fifo_clk,
   input  logic                  fifo_rstn,
   input  logic                  fifo_clear,
   input  logic                  fifo_inc,
   input  logic [ADDR_WIDTH:0]   prog_thresh,
   input  logic [ADDR_WIDTH:0]   ptr_gray_other,
   output logic                  fifo_cen,
   output logic [ADDR_WIDTH-1:0] fifo_addr,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic [ADDR_WIDTH:0]   fifo_level,
   output logic                  fifo_prog,
   output logic                  fifo_err,
   output logic [ADDR_WIDTH:0]   ptr_gray,
   output logic [ADDR_WIDTH:0]   ptr_bin,
   output logic [ADDR_WIDTH:0]   ptr_bin_other
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam bit WR = (IS_WRITE != 0);
   localparam logic [PW-1:0]         OFF      = PW'((1 << ADDR_WIDTH) - FIFO_DEPTH);
   localparam logic [PW-1:0]         DEPTH_P  = PW'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIFO_DEPTH - 1);

   // The upper lap is shifted to the top of the code space so the wrap is a single-bit gray step.
   function automatic logic [PW-1:0] ptr2gray(input logic [PW-1:0] p);
      logic [PW-1:0] e;
      e = p + (p[PW-1] ? OFF : '0);
      return e ^ (e >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2ptr(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = '0;
      b[PW-1] = g[PW-1];
      for (int k = PW - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b[PW-1] ? (b - OFF) : b;
   endfunction

   logic [PW-1:0] ptr_bin_q, ptr_bin_d;
   logic [PW-1:0] ptr_gray_q, ptr_gray_d;
   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic          err_q, err_d;
   logic          prog_q, prog_d;

   logic [PW-1:0] remote, wr_p, rd_p, ptr_next, level;
   logic          blocked, accept;

   assign remote = gray2ptr(sync_q[SYNC_STAGES-1]);
   assign wr_p   = WR ? ptr_bin_q : remote;
   assign rd_p   = WR ? remote : ptr_bin_q;

   always_comb begin
      level = '0;
      if (wr_p[PW-1] == rd_p[PW-1])
         level = {1'b0, wr_p[ADDR_WIDTH-1:0]} - {1'b0, rd_p[ADDR_WIDTH-1:0]};
      else
         level = DEPTH_P + {1'b0, wr_p[ADDR_WIDTH-1:0]} - {1'b0, rd_p[ADDR_WIDTH-1:0]};
   end

   assign fifo_full  = (level == DEPTH_P);
   assign fifo_empty = (level == '0);
   assign blocked    = WR ? fifo_full : fifo_empty;
   assign accept     = fifo_inc & ~fifo_clear & ~blocked;

   assign ptr_next = (ptr_bin_q[ADDR_WIDTH-1:0] == LAST_IDX) ?
                     {~ptr_bin_q[PW-1], {ADDR_WIDTH{1'b0}}} : (ptr_bin_q + PW'(1));

   always_comb begin
      ptr_bin_d  = ptr_bin_q;
      ptr_gray_d = ptr_gray_q;
      if (accept) begin
         ptr_bin_d  = ptr_next;
         ptr_gray_d = ptr2gray(ptr_next);
      end
      err_d  = err_q | (fifo_inc & blocked);
      prog_d = WR ? (level >= prog_thresh) : (level <= prog_thresh);
   end

   always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
      if (!fifo_rstn) begin
         ptr_bin_q  <= '0;
         ptr_gray_q <= '0;
         err_q      <= 1'b0;
         prog_q     <= ~WR;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else if (fifo_clear) begin
         ptr_bin_q  <= '0;
         ptr_gray_q <= '0;
         err_q      <= 1'b0;
         prog_q     <= ~WR;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         ptr_bin_q  <= ptr_bin_d;
         ptr_gray_q <= ptr_gray_d;
         err_q      <= err_d;
         prog_q     <= prog_d;
         sync_q[0]  <= ptr_gray_other;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Gate on reset so no RAM access can start while reset is held.
   assign fifo_cen      = ~(accept & fifo_rstn);
   assign fifo_addr     = ptr_bin_q[ADDR_WIDTH-1:0];
   assign fifo_level    = level;
   assign fifo_prog     = prog_q;
   assign fifo_err      = err_q;
   assign ptr_gray      = ptr_gray_q;
   assign ptr_bin       = ptr_bin_q;
   assign ptr_bin_other = remote;

endmodule

// File: tb/tb_pcieifc_fifo_ptr_ctrl_ext.sv
// Bench for the FIFO pointer controller: 32-deep write side, 12-deep write side and 12-deep read side.
module tb_pcieifc_fifo_ptr_ctrl_ext;

   localparam int D = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   int   n_chk = 0;
   int   n_pass = 0;

   // 32-deep write side
   logic       a_clear, a_inc, a_cen, a_full, a_empty, a_prog, a_err;
   logic [5:0] a_thr, a_other, a_level, a_gray, a_bin, a_bin_o;
   logic [4:0] a_addr;
   // 12-deep write side
   logic       w_clear, w_inc, w_cen, w_full, w_empty, w_prog, w_err, loop_en;
   logic [4:0] w_thr, w_other, w_other_drv, w_level, w_gray, w_bin, w_bin_o;
   logic [3:0] w_addr;
   // 12-deep read side
   logic       r_clear, r_inc, r_cen, r_full, r_empty, r_prog, r_err;
   logic [4:0] r_thr, r_other, r_level, r_gray, r_bin, r_bin_o;
   logic [3:0] r_addr;

   assign w_other = loop_en ? w_gray : w_other_drv;

   pcieifc_fifo_ptr_ctrl_ext #(.ADDR_WIDTH(5), .FIFO_DEPTH(32), .SYNC_STAGES(2), .IS_WRITE(1)) u_a (
      .fifo_clk(clk), .fifo_rstn(rstn), .fifo_clear(a_clear), .fifo_inc(a_inc),
      .prog_thresh(a_thr), .ptr_gray_other(a_other), .fifo_cen(a_cen), .fifo_addr(a_addr),
      .fifo_full(a_full), .fifo_empty(a_empty), .fifo_level(a_level), .fifo_prog(a_prog),
      .fifo_err(a_err), .ptr_gray(a_gray), .ptr_bin(a_bin), .ptr_bin_other(a_bin_o));

   pcieifc_fifo_ptr_ctrl_ext #(.ADDR_WIDTH(4), .FIFO_DEPTH(D), .SYNC_STAGES(2), .IS_WRITE(1)) u_w (
      .fifo_clk(clk), .fifo_rstn(rstn), .fifo_clear(w_clear), .fifo_inc(w_inc),
      .prog_thresh(w_thr), .ptr_gray_other(w_other), .fifo_cen(w_cen), .fifo_addr(w_addr),
      .fifo_full(w_full), .fifo_empty(w_empty), .fifo_level(w_level), .fifo_prog(w_prog),
      .fifo_err(w_err), .ptr_gray(w_gray), .ptr_bin(w_bin), .ptr_bin_other(w_bin_o));

   pcieifc_fifo_ptr_ctrl_ext #(.ADDR_WIDTH(4), .FIFO_DEPTH(D), .SYNC_STAGES(2), .IS_WRITE(0)) u_r (
      .fifo_clk(clk), .fifo_rstn(rstn), .fifo_clear(r_clear), .fifo_inc(r_inc),
      .prog_thresh(r_thr), .ptr_gray_other(r_other), .fifo_cen(r_cen), .fifo_addr(r_addr),
      .fifo_full(r_full), .fifo_empty(r_empty), .fifo_level(r_level), .fifo_prog(r_prog),
      .fifo_err(r_err), .ptr_gray(r_gray), .ptr_bin(r_bin), .ptr_bin_other(r_bin_o));

   // Reference: a pointer is a count c in 0..2D-1; lap = c >= D, index = c mod D.
   function automatic logic [4:0] m_bin(input int c);
      return (c >= D) ? 5'(16 + c - D) : 5'(c);
   endfunction

   // Second lap occupies codes 32-D .. 31, so the lap wrap lands next to code 0.
   function automatic logic [4:0] m_gray(input int c);
      int e;
      e = (c < D) ? c : (32 - D) + (c - D);
      return 5'(e ^ (e >> 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_w();
      w_clear = 1'b1; w_inc = 1'b0; tick(); w_clear = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      repeat (2) tick();
      n_chk++; if (a_gray !== 6'd0) $display("FAIL reset_gray got %0d want 0", a_gray); else n_pass++;
      n_chk++; if (a_bin !== 6'd0 || a_bin_o !== 6'd0 || a_addr !== 5'd0)
         $display("FAIL reset_ptrs got bin %0d other %0d addr %0d want 0", a_bin, a_bin_o, a_addr); else n_pass++;
      n_chk++; if (a_level !== 6'd0) $display("FAIL reset_level got %0d want 0", a_level); else n_pass++;
      n_chk++; if (a_empty !== 1'b1 || a_full !== 1'b0)
         $display("FAIL reset_flags got empty %0b full %0b want 1 0", a_empty, a_full); else n_pass++;
      n_chk++; if (a_cen !== 1'b1 || a_err !== 1'b0 || a_prog !== 1'b0)
         $display("FAIL reset_cen_err_prog got %0b %0b %0b want 1 0 0", a_cen, a_err, a_prog); else n_pass++;
      n_chk++; if (r_prog !== 1'b1) $display("FAIL reset_rd_prog got %0b want 1", r_prog); else n_pass++;
   endtask

   task automatic test_gray_lap();
      logic [4:0] prev;
      loop_en = 1'b1;
      clear_w();
      prev = w_gray;
      for (int n = 1; n <= 30; n++) begin
         w_inc = 1'b1;
         tick();
         n_chk++; if (w_gray !== m_gray(n % (2*D)))
            $display("FAIL gray_step%0d got %b want %b", n, w_gray, m_gray(n % (2*D))); else n_pass++;
         n_chk++; if (w_bin !== m_bin(n % (2*D)))
            $display("FAIL bin_step%0d got %0d want %0d", n, w_bin, m_bin(n % (2*D))); else n_pass++;
         n_chk++; if ($countones(prev ^ w_gray) != 1)
            $display("FAIL gray_onebit%0d got %0d bits want 1", n, $countones(prev ^ w_gray)); else n_pass++;
         if (n == D) begin
            n_chk++; if (w_gray !== 5'b11110) $display("FAIL gray_lap1_start got %b want 11110", w_gray); else n_pass++;
         end
         if (n >= 2) begin
            n_chk++; if (w_bin_o !== m_bin((n - 2) % (2*D)))
               $display("FAIL loopback%0d got %0d want %0d", n, w_bin_o, m_bin((n - 2) % (2*D))); else n_pass++;
         end
         prev = w_gray;
      end
      w_inc = 1'b0;
      loop_en = 1'b0;
      w_other_drv = 5'd0;
      clear_w();
   endtask

   task automatic test_write_full();
      clear_w();
      for (int k = 1; k <= D; k++) begin
         w_inc = 1'b1;
         #1;
         n_chk++; if (w_cen !== 1'b0 || w_addr !== 4'(k - 1))
            $display("FAIL push%0d got cen %0b addr %0d want 0 %0d", k, w_cen, w_addr, k - 1); else n_pass++;
         tick();
         n_chk++; if (w_level !== 5'(k)) $display("FAIL push_level%0d got %0d want %0d", k, w_level, k); else n_pass++;
      end
      n_chk++; if (w_full !== 1'b1) $display("FAIL full_flag got %0b want 1", w_full); else n_pass++;
      w_inc = 1'b1;
      #1;
      n_chk++; if (w_cen !== 1'b1) $display("FAIL overflow_cen got %0b want 1", w_cen); else n_pass++;
      tick();
      w_inc = 1'b0;
      n_chk++; if (w_err !== 1'b1) $display("FAIL overflow_err got %0b want 1", w_err); else n_pass++;
      n_chk++; if (w_bin !== 5'b10000) $display("FAIL overflow_ptr got %0d want 16", w_bin); else n_pass++;
      clear_w();
      n_chk++; if (w_err !== 1'b0 || w_level !== 5'd0 || w_empty !== 1'b1)
         $display("FAIL clear_after_full got err %0b level %0d empty %0b want 0 0 1", w_err, w_level, w_empty); else n_pass++;
   endtask

   task automatic test_prog_write();
      w_thr = 5'd8;
      clear_w();
      repeat (7) begin w_inc = 1'b1; tick(); end
      n_chk++; if (w_level !== 5'd7 || w_prog !== 1'b0)
         $display("FAIL prog_l7 got level %0d prog %0b want 7 0", w_level, w_prog); else n_pass++;
      tick();
      w_inc = 1'b0;
      n_chk++; if (w_level !== 5'd8 || w_prog !== 1'b0)
         $display("FAIL prog_l8_same got level %0d prog %0b want 8 0", w_level, w_prog); else n_pass++;
      tick();
      n_chk++; if (w_prog !== 1'b1) $display("FAIL prog_l8_next got %0b want 1", w_prog); else n_pass++;
   endtask

   task automatic test_read_side();
      r_thr = 5'd2;
      r_clear = 1'b1; r_other = 5'd0; tick(); r_clear = 1'b0;
      n_chk++; if (r_prog !== 1'b1 || r_empty !== 1'b1 || r_full !== 1'b0)
         $display("FAIL rd_clear got prog %0b empty %0b full %0b want 1 1 0", r_prog, r_empty, r_full); else n_pass++;
      r_other = m_gray(5);
      tick();
      n_chk++; if (r_empty !== 1'b1) $display("FAIL rd_sync_edge1 got empty %0b want 1", r_empty); else n_pass++;
      tick();
      n_chk++; if (r_level !== 5'd5 || r_empty !== 1'b0 || r_bin_o !== 5'd5)
         $display("FAIL rd_sync_edge2 got level %0d empty %0b other %0d want 5 0 5", r_level, r_empty, r_bin_o); else n_pass++;
      tick();
      n_chk++; if (r_prog !== 1'b0) $display("FAIL rd_prog_l5 got %0b want 0", r_prog); else n_pass++;
      for (int k = 1; k <= 5; k++) begin
         r_inc = 1'b1;
         #1;
         n_chk++; if (r_cen !== 1'b0 || r_addr !== 4'(k - 1))
            $display("FAIL pop%0d got cen %0b addr %0d want 0 %0d", k, r_cen, r_addr, k - 1); else n_pass++;
         tick();
         n_chk++; if (r_level !== 5'(5 - k) || r_prog !== ((6 - k) <= 2))
            $display("FAIL pop_state%0d got level %0d prog %0b want %0d %0b", k, r_level, r_prog, 5 - k, (6 - k) <= 2); else n_pass++;
      end
      n_chk++; if (r_empty !== 1'b1) $display("FAIL rd_empty got %0b want 1", r_empty); else n_pass++;
      #1;
      n_chk++; if (r_cen !== 1'b1) $display("FAIL underflow_cen got %0b want 1", r_cen); else n_pass++;
      tick();
      r_inc = 1'b0;
      n_chk++; if (r_err !== 1'b1 || r_bin !== 5'd5 || r_gray !== m_gray(5))
         $display("FAIL underflow got err %0b ptr %0d gray %b want 1 5 %b", r_err, r_bin, r_gray, m_gray(5)); else n_pass++;
   endtask

   task automatic test_clear_with_inc();
      clear_w();
      repeat (4) begin w_inc = 1'b1; tick(); end
      n_chk++; if (w_level !== 5'd4) $display("FAIL cwi_level got %0d want 4", w_level); else n_pass++;
      w_inc = 1'b1; w_clear = 1'b1;
      #1;
      n_chk++; if (w_cen !== 1'b1) $display("FAIL cwi_cen got %0b want 1", w_cen); else n_pass++;
      tick();
      w_inc = 1'b0; w_clear = 1'b0;
      n_chk++; if (w_bin !== 5'd0 || w_err !== 1'b0 || w_level !== 5'd0)
         $display("FAIL cwi_state got ptr %0d err %0b level %0d want 0 0 0", w_bin, w_err, w_level); else n_pass++;
   endtask

   // Random pushes against a remote reader that drains at random; the visible read count lags two edges.
   task automatic test_random();
      int wa, ra, vis, lvl;
      bit inc, mfull, merr, mprog;
      int hist[$];
      w_thr = 5'd6;
      w_other_drv = 5'd0;
      clear_w();
      wa = 0; ra = 0; merr = 1'b0; mprog = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         inc = ($urandom_range(0, 3) != 0);
         if (ra < wa && $urandom_range(0, 1) == 1) ra++;
         hist.push_back(ra);
         vis = (hist.size() >= 3) ? hist[hist.size() - 3] : 0;
         lvl = wa - vis;
         mfull = (lvl == D);
         w_inc = inc;
         w_other_drv = m_gray(ra % (2*D));
         #1;
         n_chk++; if (w_level !== 5'(lvl)) $display("FAIL rnd_level c%0d got %0d want %0d", cyc, w_level, lvl); else n_pass++;
         n_chk++; if (w_full !== mfull) $display("FAIL rnd_full c%0d got %0b want %0b", cyc, w_full, mfull); else n_pass++;
         n_chk++; if (w_cen !== !(inc && !mfull)) $display("FAIL rnd_cen c%0d got %0b want %0b", cyc, w_cen, !(inc && !mfull)); else n_pass++;
         n_chk++; if (w_err !== merr) $display("FAIL rnd_err c%0d got %0b want %0b", cyc, w_err, merr); else n_pass++;
         n_chk++; if (w_prog !== mprog) $display("FAIL rnd_prog c%0d got %0b want %0b", cyc, w_prog, mprog); else n_pass++;
         tick();
         mprog = (lvl >= 6);
         if (inc && mfull) merr = 1'b1;
         if (inc && !mfull) wa++;
      end
      w_inc = 1'b0;
   endtask

   task automatic test_mid_reset();
      w_other_drv = 5'd0;
      clear_w();
      repeat (3) begin w_inc = 1'b1; tick(); end
      n_chk++; if (w_level !== 5'd3) $display("FAIL burst_level got %0d want 3", w_level); else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_chk++; if (w_bin !== 5'd0 || w_gray !== 5'd0 || w_level !== 5'd0)
         $display("FAIL midrst_ptr got bin %0d gray %0d level %0d want 0 0 0", w_bin, w_gray, w_level); else n_pass++;
      n_chk++; if (w_cen !== 1'b1 || w_err !== 1'b0 || r_prog !== 1'b1 || r_err !== 1'b0)
         $display("FAIL midrst_ctl got cen %0b err %0b rprog %0b rerr %0b want 1 0 1 0", w_cen, w_err, r_prog, r_err); else n_pass++;
      tick();
      n_chk++; if (w_bin !== 5'd0 || w_cen !== 1'b1)
         $display("FAIL midrst_held got bin %0d cen %0b want 0 1", w_bin, w_cen); else n_pass++;
      w_inc = 1'b0;
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      rstn = 1'b0;
      a_clear = 1'b0; a_inc = 1'b0; a_thr = 6'd1; a_other = 6'd0;
      w_clear = 1'b0; w_inc = 1'b0; w_thr = 5'd1; w_other_drv = 5'd0; loop_en = 1'b0;
      r_clear = 1'b0; r_inc = 1'b0; r_thr = 5'd2; r_other = 5'd0;
      @(negedge clk);
      test_reset();
      test_gray_lap();
      test_write_full();
      test_prog_write();
      test_read_side();
      test_clear_with_inc();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
